// File: rtl/bpsk_pkg.sv
// rtl/bpsk_pkg.sv - shared types, sync word default, tdata field map and popcount for the BPSK slicer
package bpsk_pkg;

    typedef enum logic {HUNT, LOCKED} slicer_state_t;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h1ACFFC1D;

    // Costas loop output beat layout: {Q, I}
    localparam int I_LSB = 0;
    localparam int I_MSB = 15;
    localparam int Q_LSB = 16;
    localparam int Q_MSB = 31;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_correlator.sv
// rtl/sync_correlator.sv - Hamming-distance sync word match against both carrier polarities
module sync_correlator
    import bpsk_pkg::*;
(
    input  logic [31:0] sreg,
    input  logic [31:0] sync_word,
    input  logic [5:0]  max_err,
    output logic        match_true,
    output logic        match_inv
);

    logic [5:0] d0;
    logic [5:0] d1;

    always_comb begin
        d0         = popcount32(sreg ^ sync_word);
        d1         = popcount32(sreg ^ ~sync_word);
        match_true = (d0 <= max_err);
        match_inv  = (d1 <= max_err);
    end

endmodule

// File: rtl/bpsk_frame_slicer.sv
// rtl/bpsk_frame_slicer.sv - integrate-and-dump slicer, sync hunt and payload byte packer; BPSK_SLICER_SYMTAP_EN adds symbol tap
module bpsk_frame_slicer
    import bpsk_pkg::*;
#(
    parameter int          SPS         = 8,
    parameter logic [31:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
    parameter int          MAX_ERR     = 2,
    parameter int          FRAME_BYTES = 64
) (
    input  logic        s00_axis_aclk,
    input  logic        s00_axis_areset,
    input  logic        s00_axis_tvalid,
    output logic        s00_axis_tready,
    input  logic [31:0] s00_axis_tdata,
    input  logic        s00_axis_tlast,
    output logic        m00_axis_tvalid,
    input  logic        m00_axis_tready,
    output logic [7:0]  m00_axis_tdata,
    output logic        m00_axis_tlast,
    output logic        locked,
    output logic        inverted,
    output logic        frame_abort
`ifdef BPSK_SLICER_SYMTAP_EN
    ,
    output logic [15:0] sym_tap,
    output logic        sym_tap_valid
`endif
);

    localparam int SW  = $clog2(SPS);
    localparam int AW  = 16 + SW + 1;
    localparam int BCW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [SW-1:0]  LAST_SAMPLE = SW'(SPS - 1);
    localparam logic [BCW-1:0] LAST_BYTE   = BCW'(FRAME_BYTES - 1);

    slicer_state_t        state;
    slicer_state_t        state_nxt;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] i_ext;
    logic signed [AW-1:0] sum;
    logic [SW-1:0]        smp_cnt;
    logic [31:0]          sreg;
    logic [31:0]          sreg_shift;
    logic [6:0]           byte_sr;
    logic [2:0]           bit_cnt;
    logic [BCW-1:0]       byte_cnt;
    logic                 inv_q;
    logic                 out_valid;
    logic                 out_last;
    logic [7:0]           out_data;
    logic                 abort_q;
    logic                 beat;
    logic                 sym_done;
    logic                 sym_bit;
    logic                 pay_bit;
    logic                 match_true;
    logic                 match_inv;
    logic                 hunt_hit;
    logic                 byte_done;
    logic                 frame_done;
    logic                 abort_now;
    logic                 unused_q;

    assign unused_q = ^s00_axis_tdata[Q_MSB:Q_LSB];

    // Accept only when the output register can take a byte completing on this beat
    assign s00_axis_tready = !(out_valid && !m00_axis_tready);
    assign beat            = s00_axis_tvalid && s00_axis_tready;

    assign i_ext      = {{(AW-16){s00_axis_tdata[I_MSB]}}, s00_axis_tdata[I_MSB:I_LSB]};
    assign sum        = acc + i_ext;
    assign sym_done   = beat && (smp_cnt == LAST_SAMPLE);
    assign sym_bit    = !sum[AW-1];
    assign sreg_shift = {sreg[30:0], sym_bit};
    assign pay_bit    = sym_bit ^ inv_q;

    assign hunt_hit   = sym_done && (state == HUNT) && (match_true || match_inv);
    assign byte_done  = sym_done && (state == LOCKED) && (bit_cnt == 3'd7);
    assign frame_done = byte_done && (byte_cnt == LAST_BYTE);
    assign abort_now  = beat && s00_axis_tlast && (state == LOCKED) && !frame_done;

    sync_correlator u_corr (
        .sreg       (sreg_shift),
        .sync_word  (SYNC_WORD),
        .max_err    (6'(MAX_ERR)),
        .match_true (match_true),
        .match_inv  (match_inv)
    );

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:    if (hunt_hit) state_nxt = LOCKED;
            LOCKED:  if (frame_done || abort_now) state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    always_comb begin
        locked = (state == LOCKED);
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            acc       <= '0;
            smp_cnt   <= '0;
            sreg      <= '0;
            byte_sr   <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            inv_q     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            abort_q   <= 1'b0;
        end else begin
            if (beat) begin
                if (s00_axis_tlast || (smp_cnt == LAST_SAMPLE)) begin
                    acc     <= '0;
                    smp_cnt <= '0;
                end else begin
                    acc     <= sum;
                    smp_cnt <= smp_cnt + 1'b1;
                end
            end

            if (sym_done && (state == HUNT)) begin
                sreg <= sreg_shift;
                if (hunt_hit) begin
                    inv_q    <= !match_true;
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                end
            end

            if (sym_done && (state == LOCKED)) begin
                byte_sr <= {byte_sr[5:0], pay_bit};
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end

            // End of frame or abort: restart the hunt from a clean shift register
            if (frame_done || abort_now) begin
                sreg     <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end

            if (byte_done) begin
                out_valid <= 1'b1;
                out_data  <= {byte_sr, pay_bit};
                out_last  <= frame_done;
            end else if (m00_axis_tready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            abort_q <= abort_now;
        end
    end

    assign m00_axis_tvalid = out_valid;
    assign m00_axis_tdata  = out_data;
    assign m00_axis_tlast  = out_last;
    assign inverted        = inv_q;
    assign frame_abort     = abort_q;

`ifdef BPSK_SLICER_SYMTAP_EN
    localparam logic signed [AW-1:0] TAP_MAX = AW'(32767);
    localparam logic signed [AW-1:0] TAP_MIN = AW'(-32768);

    logic signed [AW-1:0] tap_sh;
    assign tap_sh = sum >>> SW;

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            sym_tap       <= '0;
            sym_tap_valid <= 1'b0;
        end else begin
            sym_tap_valid <= sym_done;
            if (sym_done) begin
                if (tap_sh > TAP_MAX) begin
                    sym_tap <= 16'h7FFF;
                end else if (tap_sh < TAP_MIN) begin
                    sym_tap <= 16'h8000;
                end else begin
                    sym_tap <= tap_sh[15:0];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_bpsk_frame_slicer.sv
// tb/tb_bpsk_frame_slicer.sv - directed bench for bpsk_frame_slicer with hand-computed expectations
module tb_bpsk_frame_slicer;

    localparam logic [31:0] SYNC = 32'h1ACFFC1D;

    logic        s00_axis_aclk = 1'b0;
    logic        s00_axis_areset;
    logic        s00_axis_tvalid;
    logic        s00_axis_tready;
    logic [31:0] s00_axis_tdata;
    logic        s00_axis_tlast;
    logic        m00_axis_tvalid;
    logic        m00_axis_tready;
    logic [7:0]  m00_axis_tdata;
    logic        m00_axis_tlast;
    logic        locked;
    logic        inverted;
    logic        frame_abort;
`ifdef BPSK_SLICER_SYMTAP_EN
    logic [15:0] sym_tap;
    logic        sym_tap_valid;
`endif

    int n_vec     = 0;
    int n_bad     = 0;
    int abort_cnt = 0;
    logic [7:0] got_data[$];
    logic       got_last[$];

    always #5 s00_axis_aclk = ~s00_axis_aclk;

    bpsk_frame_slicer dut (
        .s00_axis_aclk   (s00_axis_aclk),
        .s00_axis_areset (s00_axis_areset),
        .s00_axis_tvalid (s00_axis_tvalid),
        .s00_axis_tready (s00_axis_tready),
        .s00_axis_tdata  (s00_axis_tdata),
        .s00_axis_tlast  (s00_axis_tlast),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tready (m00_axis_tready),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tlast  (m00_axis_tlast),
        .locked          (locked),
        .inverted        (inverted),
        .frame_abort     (frame_abort)
`ifdef BPSK_SLICER_SYMTAP_EN
        ,
        .sym_tap         (sym_tap),
        .sym_tap_valid   (sym_tap_valid)
`endif
    );

    // Inputs change on the falling edge; the monitor samples 1 unit later
    always @(negedge s00_axis_aclk) begin
        #1;
        if (!s00_axis_areset) begin
            if (m00_axis_tvalid && m00_axis_tready) begin
                got_data.push_back(m00_axis_tdata);
                got_last.push_back(m00_axis_tlast);
            end
            if (frame_abort) abort_cnt++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_sample(input logic signed [15:0] i, input bit last);
        int guard;
        s00_axis_tdata  = {16'h0, i};
        s00_axis_tlast  = last;
        s00_axis_tvalid = 1'b1;
        guard = 0;
        #1;
        while (!s00_axis_tready && guard < 1000) begin
            @(negedge s00_axis_aclk);
            #1;
            guard++;
        end
        if (guard >= 1000) chk("tready_timeout", {31'd0, s00_axis_tready}, 32'd1);
        @(negedge s00_axis_aclk);
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
    endtask

    task automatic send_bit(input bit b, input bit neg, input int last_at);
        for (int s = 0; s < 8; s++) begin
            send_sample((b ^ neg) ? 16'sd1000 : -16'sd1000, s == last_at);
            if (s == last_at) break;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit neg);
        for (int k = 7; k >= 0; k--) send_bit(v[k], neg, -1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit neg);
        for (int k = 31; k >= 0; k--) send_bit(w[k], neg, -1);
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int g;
        g = 0;
        #2;
        while (got_data.size() < n && g < 300) begin
            @(negedge s00_axis_aclk);
            #2;
            g++;
        end
        chk(tag, got_data.size(), n);
        @(negedge s00_axis_aclk);
    endtask

    task automatic check_seq(input string tag, input int n, input int base, input int step, input bit want_last);
        logic [31:0] e;
        for (int k = 0; k < n && k < got_data.size(); k++) begin
            e = {23'd0, (want_last && k == n - 1), 8'(base + step * k)};
            chk(tag, {23'd0, got_last[k], got_data[k]}, e);
        end
    endtask

    initial begin
        s00_axis_areset = 1'b1;
        s00_axis_tvalid = 1'b0;
        s00_axis_tdata  = '0;
        s00_axis_tlast  = 1'b0;
        m00_axis_tready = 1'b1;

        // 1: reset state
        repeat (3) @(negedge s00_axis_aclk);
        #2;
        chk("rst_m_tvalid", {31'd0, m00_axis_tvalid}, 32'd0);
        chk("rst_m_tdata", {24'd0, m00_axis_tdata}, 32'd0);
        chk("rst_m_tlast", {31'd0, m00_axis_tlast}, 32'd0);
        chk("rst_s_tready", {31'd0, s00_axis_tready}, 32'd1);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_inverted", {31'd0, inverted}, 32'd0);
        chk("rst_frame_abort", {31'd0, frame_abort}, 32'd0);
        @(negedge s00_axis_aclk);
        s00_axis_areset = 1'b0;

        // 2: true polarity frame 0x00..0x3F
        got_data.delete(); got_last.delete();
        send_word(SYNC, 1'b0);
        #2;
        chk("t2_locked", {31'd0, locked}, 32'd1);
        chk("t2_inverted", {31'd0, inverted}, 32'd0);
        @(negedge s00_axis_aclk);
        for (int k = 0; k < 64; k++) send_byte(8'(k), 1'b0);
        wait_bytes("t2_count", 64);
        check_seq("t2_byte", 64, 0, 1, 1'b1);
        #2;
        chk("t2_unlocked", {31'd0, locked}, 32'd0);
        chk("t2_inv_end", {31'd0, inverted}, 32'd0);
        @(negedge s00_axis_aclk);

        // 3: same frame through a 180 degree rotated carrier
        got_data.delete(); got_last.delete();
        send_word(SYNC, 1'b1);
        #2;
        chk("t3_locked", {31'd0, locked}, 32'd1);
        chk("t3_inverted", {31'd0, inverted}, 32'd1);
        @(negedge s00_axis_aclk);
        for (int k = 0; k < 64; k++) send_byte(8'(k), 1'b1);
        wait_bytes("t3_count", 64);
        check_seq("t3_byte", 64, 0, 1, 1'b1);
        #2;
        chk("t3_unlocked", {31'd0, locked}, 32'd0);
        chk("t3_inv_end", {31'd0, inverted}, 32'd1);
        @(negedge s00_axis_aclk);

        // 4: three bit errors rejected, two accepted
        got_data.delete(); got_last.delete();
        send_word(SYNC ^ 32'h80010001, 1'b0);
        send_word(32'h0, 1'b0);
        #2;
        chk("t4_err3_locked", {31'd0, locked}, 32'd0);
        chk("t4_err3_bytes", got_data.size(), 0);
        @(negedge s00_axis_aclk);
        send_word(SYNC ^ 32'h80000001, 1'b0);
        #2;
        chk("t4_err2_locked", {31'd0, locked}, 32'd1);
        chk("t4_err2_inverted", {31'd0, inverted}, 32'd0);
        @(negedge s00_axis_aclk);
        for (int k = 0; k < 64; k++) send_byte(8'(255 - k), 1'b0);
        wait_bytes("t4_count", 64);
        check_seq("t4_byte", 64, 255, -1, 1'b1);

        // 5: downstream stall of 200 cycles mid-frame
        got_data.delete(); got_last.delete();
        fork
            begin
                repeat (800) @(negedge s00_axis_aclk);
                m00_axis_tready = 1'b0;
                repeat (100) @(negedge s00_axis_aclk);
                #2;
                chk("t5_stall_tready", {31'd0, s00_axis_tready}, 32'd0);
                chk("t5_stall_tvalid", {31'd0, m00_axis_tvalid}, 32'd1);
                repeat (100) @(negedge s00_axis_aclk);
                m00_axis_tready = 1'b1;
            end
        join_none
        send_word(SYNC, 1'b0);
        for (int k = 0; k < 64; k++) send_byte(8'(8'h40 + k), 1'b0);
        wait_bytes("t5_count", 64);
        check_seq("t5_byte", 64, 8'h40, 1, 1'b1);

        // 6: input tlast after byte 10 aborts the frame, then relock
        got_data.delete(); got_last.delete();
        abort_cnt = 0;
        send_word(SYNC, 1'b0);
        for (int k = 0; k < 10; k++) send_byte(8'(8'h10 + k), 1'b0);
        send_bit(1'b1, 1'b0, 2);
        wait_bytes("t6_count", 10);
        check_seq("t6_byte", 10, 8'h10, 1, 1'b0);
        repeat (4) @(negedge s00_axis_aclk);
        #2;
        chk("t6_abort_pulses", abort_cnt, 1);
        chk("t6_unlocked", {31'd0, locked}, 32'd0);
        chk("t6_no_extra", got_data.size(), 10);
        @(negedge s00_axis_aclk);
        send_word(SYNC, 1'b0);
        #2;
        chk("t6_relocked", {31'd0, locked}, 32'd1);
        @(negedge s00_axis_aclk);
        send_sample(16'sd1000, 1'b1);
        repeat (3) @(negedge s00_axis_aclk);
        #2;
        chk("t6_abort2_pulses", abort_cnt, 2);
        chk("t6_abort2_unlocked", {31'd0, locked}, 32'd0);
        @(negedge s00_axis_aclk);

        // Reset with a byte parked in the output register
        m00_axis_tready = 1'b0;
        send_word(SYNC, 1'b0);
        send_byte(8'hC3, 1'b0);
        #2;
        chk("rst_mid_held_valid", {31'd0, m00_axis_tvalid}, 32'd1);
        chk("rst_mid_held_data", {24'd0, m00_axis_tdata}, 32'hC3);
        @(negedge s00_axis_aclk);
        s00_axis_areset = 1'b1;
        @(negedge s00_axis_aclk);
        #2;
        chk("rst_mid_tvalid", {31'd0, m00_axis_tvalid}, 32'd0);
        chk("rst_mid_locked", {31'd0, locked}, 32'd0);
        chk("rst_mid_s_tready", {31'd0, s00_axis_tready}, 32'd1);
        @(negedge s00_axis_aclk);
        s00_axis_areset = 1'b0;
        m00_axis_tready = 1'b1;
        repeat (2) @(negedge s00_axis_aclk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
